// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned FETCH_ADDR_W = 64;
    localparam int unsigned FETCH_BUS_W  = 64;
    localparam int unsigned FETCH_INST_W = 32;

    localparam logic [63:0] FETCH_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_word_sel.sv
// Picks the 32-bit instruction word out of a 64-bit bus beat using pc[2].
module if_fetch_unit_word_sel
    import if_fetch_unit_pkg::*;
(
    input  logic [FETCH_BUS_W-1:0]  rdata,
    input  logic                    hi_sel,
    output logic [FETCH_INST_W-1:0] word_c
);

    assign word_c = hi_sel ? rdata[FETCH_BUS_W-1:FETCH_INST_W] : rdata[FETCH_INST_W-1:0];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding bus
// fetches and holds the fetched instruction for decode.
// Optional: FETCH_MISALIGN_CHK_EN adds fetch_misalign_o and suppresses bus
// requests for redirect targets that are not 4-byte aligned.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned              ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter logic [FETCH_INST_W-1:0]  NOP_INST = FETCH_NOP_INST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_inst_valid_i,
    input  logic                    fetch_stall_i,
    input  logic                    fetch_flush_i,
    input  logic                    fetch_redirect_valid_i,
    input  logic [ADDR_W-1:0]       fetch_redirect_pc_i,
    output logic                    fetch_req_o,
    output logic [ADDR_W-1:0]       fetch_addr_o,
    input  logic                    fetch_ack_i,
    input  logic [FETCH_BUS_W-1:0]  fetch_rdata_i,
    output logic                    fetch_fetched_ok_o,
    output logic [ADDR_W-1:0]       fetch_pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic                    fetch_misalign_o,
`endif
    output logic [FETCH_INST_W-1:0] fetch_inst_o
);

    fetch_state_e            state_q, state_d;
    logic [ADDR_W-1:0]       pc_q, pc_d;
    logic [FETCH_INST_W-1:0] inst_q, inst_d;
    logic                    ok_q, ok_d;
    logic                    req_q, req_d;
    logic [FETCH_INST_W-1:0] word_c;
`ifdef FETCH_MISALIGN_CHK_EN
    logic                    mis_q, mis_d;
    logic                    redirect_mis_c;
`endif

    // Instruction word selection from the bus beat
    if_fetch_unit_word_sel u_word_sel (
        .rdata  (fetch_rdata_i),
        .hi_sel (pc_q[2]),
        .word_c (word_c)
    );

    // State and datapath registers; reset also drops an in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            ok_q    <= 1'b0;
            req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ok_q    <= ok_d;
            req_q   <= req_d;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Next-state logic; HOLD acts only on a pipeline advance, redirect first
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ok_d    = ok_q;
        req_d   = req_q;
`ifdef FETCH_MISALIGN_CHK_EN
        mis_d          = mis_q;
        redirect_mis_c = |fetch_redirect_pc_i[1:0];
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
            end
            ST_REQ: begin
                if (fetch_ack_i) begin
                    inst_d  = word_c;
                    ok_d    = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fetch_inst_valid_i) begin
                    if (fetch_redirect_valid_i) begin
                        pc_d = fetch_redirect_pc_i;
`ifdef FETCH_MISALIGN_CHK_EN
                        mis_d = redirect_mis_c;
                        if (redirect_mis_c) begin
                            inst_d = NOP_INST;
                            ok_d   = 1'b1;
                        end else begin
                            ok_d    = 1'b0;
                            req_d   = 1'b1;
                            state_d = ST_REQ;
                        end
`else
                        ok_d    = 1'b0;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
`endif
                    end else if (fetch_flush_i) begin
                        // Bubble but keep fetched_ok so the pipeline drains
                        inst_d = NOP_INST;
                    end else if (!fetch_stall_i) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        ok_d    = 1'b0;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ok_d    = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    assign fetch_req_o        = req_q;
    assign fetch_addr_o       = {pc_q[ADDR_W-1:3], 3'b000};
    assign fetch_fetched_ok_o = ok_q;
    assign fetch_pc_o         = pc_q;
    assign fetch_inst_o       = inst_q;
`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_misalign_o   = mis_q;
`endif

    // A redirect accompanied by an advance is only legal while holding
    a_redirect_only_in_hold: assert property (
        @(posedge clk) disable iff (!rst)
        (fetch_redirect_valid_i && fetch_inst_valid_i) |-> (state_q == ST_HOLD)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, stall, flush, rv, ack;
    logic [63:0] rpc, rdata;
    logic        req_o, ok_o;
    logic [63:0] addr_o, pc_o;
    logic [31:0] inst_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        mis_o;
`endif

    int total = 0;
    int bad   = 0;

    // Model: waiting for the bus, holding an instruction, or just out of reset
    bit          m_idle, m_busy, m_ok, m_mis;
    logic [63:0] m_pc;
    logic [31:0] m_inst;

    if_fetch_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .fetch_inst_valid_i     (iv),
        .fetch_stall_i          (stall),
        .fetch_flush_i          (flush),
        .fetch_redirect_valid_i (rv),
        .fetch_redirect_pc_i    (rpc),
        .fetch_req_o            (req_o),
        .fetch_addr_o           (addr_o),
        .fetch_ack_i            (ack),
        .fetch_rdata_i          (rdata),
        .fetch_fetched_ok_o     (ok_o),
        .fetch_pc_o             (pc_o),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign_o       (mis_o),
`endif
        .fetch_inst_o           (inst_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_busy = 1'b0;
        m_ok   = 1'b0;
        m_mis  = 1'b0;
        m_pc   = RST_PC;
        m_inst = NOP;
    endtask

    // One clock of the fetch stage as seen by its neighbours
    task automatic model_step();
        if (m_idle) begin
            m_idle = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy) begin
            if (ack) begin
                m_inst = m_pc[2] ? rdata[63:32] : rdata[31:0];
                m_ok   = 1'b1;
                m_busy = 1'b0;
            end
        end else if (iv) begin
            if (rv) begin
                m_pc = rpc;
`ifdef FETCH_MISALIGN_CHK_EN
                m_mis = (rpc[1:0] != 2'b00);
                if (m_mis) m_inst = NOP;
                else begin m_ok = 1'b0; m_busy = 1'b1; end
`else
                m_ok   = 1'b0;
                m_busy = 1'b1;
`endif
            end else if (flush) begin
                m_inst = NOP;
            end else if (!stall) begin
                m_pc   = m_pc + 64'd4;
                m_ok   = 1'b0;
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("req",  64'(req_o),  64'(m_busy));
        check_val("addr", addr_o,      {m_pc[63:3], 3'b000});
        check_val("ok",   64'(ok_o),   64'(m_ok));
        check_val("pc",   pc_o,        m_pc);
        check_val("inst", 64'(inst_o), 64'(m_inst));
`ifdef FETCH_MISALIGN_CHK_EN
        check_val("misalign", 64'(mis_o), 64'(m_mis));
`endif
    endtask

    task automatic quiet();
        iv = 1'b0; stall = 1'b0; flush = 1'b0; rv = 1'b0; ack = 1'b0;
    endtask

    // Inputs are set before calling; they take effect on the next rising edge
    task automatic cycle();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom % 8)
            0:       t = 64'hFFFF_FFFF_FFFF_FFFC;
            1:       t = {$urandom, $urandom};
            default: t = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
        endcase
        return t;
    endfunction

    initial begin
        rst = 1'b0;
        quiet();
        rpc   = '0;
        rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check_val("rst_req", 64'(req_o), 64'd0);
        check_val("rst_pc",  pc_o, RST_PC);

        // Reset release then a fetch acknowledged on the third request cycle
        rst = 1'b1;
        cycle();
        cycle();
        cycle();
        ack = 1'b1; rdata = 64'h0010_0093_0000_0013;
        cycle();
        check_val("first_inst", 64'(inst_o), 64'h0000_0013);
        check_val("first_ok",   64'(ok_o),   64'd1);

        // Plain advance fetches the upper word of the same beat
        ack = 1'b0; iv = 1'b1;
        cycle();
        check_val("adv_addr", addr_o, 64'h8000_0000);
        check_val("adv_pc",   pc_o,   64'h8000_0004);
        iv = 1'b0; ack = 1'b1;
        cycle();
        check_val("adv_inst", 64'(inst_o), 64'h0010_0093);

        // Stall over four advances holds everything
        quiet(); iv = 1'b1; stall = 1'b1;
        repeat (4) cycle();
        check_val("stall_pc", pc_o, 64'h8000_0004);

        // Flush bubbles the instruction, then a redirect refetches
        quiet(); iv = 1'b1; flush = 1'b1;
        cycle();
        check_val("flush_inst", 64'(inst_o), 64'(NOP));
        check_val("flush_ok",   64'(ok_o),   64'd1);
        quiet(); iv = 1'b1; rv = 1'b1; rpc = 64'h8000_0100;
        cycle();
        check_val("redir_addr", addr_o, 64'h8000_0100);
        quiet();
        cycle();
        cycle();
        ack = 1'b1; rdata = {$urandom, $urandom};
        cycle();

        // Redirect beats flush and stall in the same advance
        quiet(); iv = 1'b1; rv = 1'b1; flush = 1'b1; stall = 1'b1; rpc = 64'h8000_0200;
        cycle();
        quiet(); ack = 1'b1; rdata = {$urandom, $urandom};
        cycle();
        check_val("redir_win_pc", pc_o, 64'h8000_0200);

        // Misaligned redirect target
        quiet(); iv = 1'b1; rv = 1'b1; rpc = 64'h8000_0102;
        cycle();
`ifdef FETCH_MISALIGN_CHK_EN
        check_val("mis_req",  64'(req_o),  64'd0);
        check_val("mis_flag", 64'(mis_o),  64'd1);
        check_val("mis_inst", 64'(inst_o), 64'(NOP));
        quiet(); iv = 1'b1; rv = 1'b1; rpc = 64'h8000_0108;
        cycle();
`endif
        quiet(); ack = 1'b1; rdata = {$urandom, $urandom};
        cycle();

        // PC wraps at the top of the address space
        quiet(); iv = 1'b1; rv = 1'b1; rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        quiet(); ack = 1'b1; rdata = {$urandom, $urandom};
        cycle();
        quiet(); iv = 1'b1;
        cycle();
        check_val("wrap_pc", pc_o, 64'd0);
        quiet();

        // Reset during a request; a late ack in IDLE is ignored
        #2 rst = 1'b0;
        #1 check_val("midrst_req", 64'(req_o), 64'd0);
        check_val("midrst_pc", pc_o, RST_PC);
        model_reset();
        @(negedge clk);
        rst = 1'b1; ack = 1'b1; rdata = {$urandom, $urandom};
        cycle();
        check_val("late_ack_ok", 64'(ok_o), 64'd0);
        quiet();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            stall = (($urandom % 4) == 0);
            flush = (($urandom % 6) == 0);
            rv    = (($urandom % 5) == 0);
            iv    = m_ok && (($urandom % 10) < 7);
            ack   = m_busy && (($urandom % 3) == 0);
            rdata = {$urandom, $urandom};
            rpc   = pick_target();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
